udp_echo_ctrl: RTL
==================

// Module: udp_echo_ctrl
// PURPOSE
//  UDP loopback controller in the 156.25 MHz MAC domain. Sits upstream of the TX FIFO and downstream of the receive path.
//  Captures each received payload word-by-word into the TX FIFO, then requests transmission from the 10G UDP engine.
//  It drives data_length/tx_start and waits on tx_idle, so every received payload is echoed back to the sender.
// PARAMETERS
//  MAX_WORDS  182  max 64-bit payload words accepted per frame (182 words = 1456 bytes); excess words dropped
//  MIN_WORDS  3    min payload words transmitted when TX_PAD_EN is defined (24 bytes)
//  CNT_W      16   width of the dropped-frame counter
// PORTS
//  clk_156_25    in   1      MAC-side clock; all logic on rising edge
//  rst           in   1      synchronous, active-high reset
//  rx_wr_req     in   1      received payload word valid
//  rx_data       in   64     received payload word
//  rx_finish     in   1      1-cycle pulse: end of received payload
//  wrfull        in   1      TX FIFO full
//  fifo_wrreq    out  1      TX FIFO write request
//  fifo_data     out  64     TX FIFO write data
//  tx_idle       in   1      UDP engine idle, ready to accept tx_start
//  tx_start      out  1      transmit request, held until tx_idle deasserts
//  data_length   out  16     payload length in bytes, stable while tx_start=1
//  truncated     out  1      sticky: a word was lost to MAX_WORDS or wrfull; cleared by reset only
//  drop_frames   out  CNT_W  frames ignored while busy; saturates at all-ones
// BEHAVIOUR
//  Reset: all outputs 0; state=IDLE; word counter=0.
//  Write path:
//   - fifo_wrreq/fifo_data are registered, 1-cycle latency from rx_wr_req/rx_data.
//   - A word is written only when state is IDLE or CAP, wrfull=0 and word count < MAX_WORDS.
//   - Otherwise the word is not written and truncated is set.
//   - Counter increments per written word only.
//  FSM:
//   - IDLE -> CAP on first accepted rx_wr_req.
//   - IDLE with rx_finish and no words: stays IDLE; no tx_start; not counted as a drop.
//   - CAP -> LEN on rx_finish. A word on the same cycle as rx_finish is included.
//   - LEN: data_length <= count*8 (16-bit, zero-extended); -> PAD if TX_PAD_EN, else -> WAIT.
//   - PAD: writes 64'h0 words while count < MIN_WORDS and wrfull=0; stalls when wrfull=1; -> WAIT.
//   - WAIT: when tx_idle=1, assert tx_start -> START.
//   - START: hold tx_start=1 until tx_idle=0 is seen, then deassert tx_start, clear count -> IDLE.
//  Busy handling:
//   - rx_wr_req in LEN/PAD/WAIT/START: word discarded, no FIFO write.
//   - rx_finish in any of those states: drop_frames +1, saturating.
//  Length rule: data_length reflects words actually written (including pads), never requested words.
//  rst during any state: FSM to IDLE, tx_start dropped in same cycle; FIFO contents are cleared by its own aclr.
// CONFIGURATION
//  TX_PAD_EN defined:
//   - PAD state present; short frames padded with zero words to MIN_WORDS.
//   - data_length >= MIN_WORDS*8 for any non-empty frame.
//  TX_PAD_EN undefined:
//   - PAD state and MIN_WORDS unused; LEN -> WAIT directly.
//   - data_length = written words*8 exactly.
// TESTING
//  1) 4 words + rx_finish on last word; tx_idle=1:
//     -> 4 fifo writes, data_length=32, tx_start 1 until tx_idle=0, then IDLE.
//  2) 200 words:
//     -> 182 writes, data_length=1456, truncated=1.
//  3) wrfull=1 for words 2-3 of 5:
//     -> 3 writes, data_length=24, truncated=1.
//  4) Frame arrives while in WAIT (tx_idle=0):
//     -> no writes, drop_frames=1; first frame sent once tx_idle=1.
//  5) 1 word with TX_PAD_EN:
//     -> data word + 2 zero words, data_length=24.
//     Without TX_PAD_EN: data_length=8.
//  6) rst asserted in START:
//     -> tx_start=0 next cycle, state IDLE; rx_finish with no words -> no tx_start.

Source files
------------

// File: rtl/udp_echo_ctrl.sv
// UDP loopback controller: captures a received payload into the TX FIFO, then requests its echo.
// Optional zero-padding of short frames to MIN_WORDS is enabled by defining TX_PAD_EN.
module udp_echo_ctrl #(
   parameter int MAX_WORDS = 182,
   parameter int MIN_WORDS = 3,
   parameter int CNT_W     = 16
) (
   input  logic             clk_156_25,
   input  logic             rst,
   input  logic             rx_wr_req,
   input  logic [63:0]      rx_data,
   input  logic             rx_finish,
   input  logic             wrfull,
   output logic             fifo_wrreq,
   output logic [63:0]      fifo_data,
   input  logic             tx_idle,
   output logic             tx_start,
   output logic [15:0]      data_length,
   output logic             truncated,
   output logic [CNT_W-1:0] drop_frames
);

   localparam logic [15:0] MAX_W16 = 16'(MAX_WORDS);
   localparam logic [15:0] MIN_W16 = 16'(MIN_WORDS);

   typedef enum logic [2:0] {IDLE, CAP, LEN, PAD, WAIT, START} state_t;

   state_t             state_q, state_d;
   logic [15:0]        count_q, count_d;
   logic               wr_q, wr_d;
   logic [63:0]        data_q, data_d;
   logic [15:0]        len_q, len_d;
   logic               start_q, start_d;
   logic               trunc_q, trunc_d;
   logic [CNT_W-1:0]   drop_q, drop_d;
   logic               capture;
   logic               accept;

`ifndef TX_PAD_EN
   logic unused_min;
   assign unused_min = ^MIN_W16;
`endif

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      wr_d    = 1'b0;
      data_d  = data_q;
      len_d   = len_q;
      start_d = start_q;
      trunc_d = trunc_q;
      drop_d  = drop_q;

      capture = (state_q == IDLE) || (state_q == CAP);
      accept  = capture && rx_wr_req && !wrfull && (count_q < MAX_W16);

      if (capture && rx_wr_req && !accept) begin
         trunc_d = 1'b1;
      end
      if (accept) begin
         wr_d    = 1'b1;
         data_d  = rx_data;
         count_d = count_q + 16'd1;
      end
      // Frames ending while a previous echo is still in flight are only counted.
      if (!capture && rx_finish && (drop_q != '1)) begin
         drop_d = drop_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = rx_finish ? LEN : CAP;
            end
         end
         CAP: begin
            if (rx_finish) begin
               state_d = LEN;
            end
         end
         LEN: begin
            len_d = {count_q[12:0], 3'b000};
`ifdef TX_PAD_EN
            state_d = PAD;
`else
            state_d = WAIT;
`endif
         end
`ifdef TX_PAD_EN
         PAD: begin
            if (count_q >= MIN_W16) begin
               len_d   = {count_q[12:0], 3'b000};
               state_d = WAIT;
            end else if (!wrfull) begin
               wr_d    = 1'b1;
               data_d  = 64'h0;
               count_d = count_q + 16'd1;
            end
         end
`endif
         WAIT: begin
            if (tx_idle) begin
               start_d = 1'b1;
               state_d = START;
            end
         end
         START: begin
            if (!tx_idle) begin
               start_d = 1'b0;
               count_d = 16'd0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_156_25) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= 16'd0;
         wr_q    <= 1'b0;
         data_q  <= 64'h0;
         len_q   <= 16'd0;
         start_q <= 1'b0;
         trunc_q <= 1'b0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         wr_q    <= wr_d;
         data_q  <= data_d;
         len_q   <= len_d;
         start_q <= start_d;
         trunc_q <= trunc_d;
         drop_q  <= drop_d;
      end
   end

   assign fifo_wrreq  = wr_q;
   assign fifo_data   = data_q;
   assign tx_start    = start_q;
   assign data_length = len_q;
   assign truncated   = trunc_q;
   assign drop_frames = drop_q;

endmodule
